// File: rtl/configure_pkg.sv
// Shared configuration package.
// Boot copier state type and write strobe constant.
package configure;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_DONE
  } boot_state_t;

  localparam logic [3:0] BOOT_WSTRB_ALL = 4'hF;

  // Word address: base plus idx*4, wrapping modulo 2^32.
  function automatic logic [31:0] boot_addr(
    input logic [31:0] base,
    input logic [15:0] idx
  );
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/boot_copy_timer.sv
// Per-request wait counter for the boot copier.
// The request cycle counts as the first waited cycle.
module boot_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 2);
  localparam logic [W-1:0] LIMIT =
    W'((TIMEOUT > 1) ? TIMEOUT - 1 : 0);

  logic [W-1:0] count;

  // Count waited cycles; saturate once the limit is hit.
  always_ff @(posedge clock) begin
    if (reset || clear)
      count <= W'(1);
    else if (enable && !expired)
      count <= count + 1'b1;
  end

  assign expired = (count >= LIMIT);

endmodule

// File: rtl/boot_copy.sv
// Boot-time ROM to RAM block copier.
// Holds the core in reset until the image has been copied.
module boot_copy
  import configure::*;
#(
  parameter logic [31:0] SRC_BASE = 32'h0000_0000,
  parameter logic [31:0] DST_BASE = 32'h8000_0000,
  parameter int unsigned WORDS    = 32,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        rom_valid,
  output logic        rom_instr,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rdata,
  input  logic        rom_ready,
  output logic        ram_valid,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wstrb,
  input  logic        ram_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        core_reset
);

  localparam logic [15:0] LAST = 16'(WORDS - 1);

  boot_state_t state;
  logic [15:0] idx;
  logic        t_clear;
  logic        t_enable;
  logic        expired;

  assign rom_instr = 1'b1;
  assign t_clear   = (state == ST_RD_REQ) ||
                     (state == ST_WR_REQ);
  assign t_enable  = (state == ST_RD_WAIT) ||
                     (state == ST_WR_WAIT);

  boot_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (t_clear),
    .enable (t_enable),
    .expired(expired)
  );

  // Copy sequencer; every output is set on the edge entering its state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      rom_valid  <= 1'b0;
      rom_addr   <= SRC_BASE;
      ram_valid  <= 1'b0;
      ram_addr   <= DST_BASE;
      ram_wdata  <= '0;
      ram_wstrb  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      core_reset <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            idx       <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b1;
            rom_valid <= 1'b1;
            rom_addr  <= SRC_BASE;
            state     <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          rom_valid <= 1'b0;
          state     <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (rom_ready) begin
            ram_valid <= 1'b1;
            ram_addr  <= boot_addr(DST_BASE, idx);
            ram_wdata <= rom_rdata;
            ram_wstrb <= BOOT_WSTRB_ALL;
            state     <= ST_WR_REQ;
          end else if (expired) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end
        end
        ST_WR_REQ: begin
          ram_valid <= 1'b0;
          ram_wstrb <= '0;
          state     <= ST_WR_WAIT;
        end
        ST_WR_WAIT: begin
          if (ram_ready) begin
            if (idx == LAST) begin
              busy  <= 1'b0;
              state <= ST_DONE;
            end else begin
              idx       <= idx + 16'd1;
              rom_valid <= 1'b1;
              rom_addr  <= boot_addr(SRC_BASE, idx + 16'd1);
              state     <= ST_RD_REQ;
            end
          end else if (expired) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done <= 1'b1;
          if (!error)
            core_reset <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_copy.sv
// Directed bench for boot_copy.
// Scoreboard queues hold expected writes and reads.
module tb_boot_copy;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start_b = 1'b0;

  always #5 clock = ~clock;

  logic        a_rom_valid, a_rom_instr;
  logic [31:0] a_rom_addr;
  logic [31:0] a_rom_rdata = '0;
  logic        a_rom_ready = 1'b0;
  logic        a_ram_valid;
  logic [31:0] a_ram_addr, a_ram_wdata;
  logic [3:0]  a_ram_wstrb;
  logic        a_ram_ready = 1'b0;
  logic        a_busy, a_done, a_error, a_core_reset;

  logic        b_rom_valid, b_rom_instr;
  logic [31:0] b_rom_addr;
  logic [31:0] b_rom_rdata = '0;
  logic        b_rom_ready = 1'b0;
  logic        b_ram_valid;
  logic [31:0] b_ram_addr, b_ram_wdata;
  logic [3:0]  b_ram_wstrb;
  logic        b_ram_ready = 1'b0;
  logic        b_busy, b_done, b_error, b_core_reset;

  int compared = 0;
  int mismatched = 0;
  int nwr = 0;
  int ram_lat = 1;
  int wcnt = 0;
  bit rom_hang = 1'b0;

  wr_t         wq_a[$];
  wr_t         wq_b[$];
  logic [31:0] rq_b[$];

  boot_copy #(
    .WORDS(4), .TIMEOUT(8)
  ) u_a (
    .clock(clock), .reset(reset), .start(start),
    .rom_valid(a_rom_valid), .rom_instr(a_rom_instr),
    .rom_addr(a_rom_addr), .rom_rdata(a_rom_rdata),
    .rom_ready(a_rom_ready),
    .ram_valid(a_ram_valid), .ram_addr(a_ram_addr),
    .ram_wdata(a_ram_wdata), .ram_wstrb(a_ram_wstrb),
    .ram_ready(a_ram_ready),
    .busy(a_busy), .done(a_done), .error(a_error),
    .core_reset(a_core_reset)
  );

  boot_copy #(
    .SRC_BASE(32'hFFFF_FFFC), .WORDS(2), .TIMEOUT(8)
  ) u_b (
    .clock(clock), .reset(reset), .start(start_b),
    .rom_valid(b_rom_valid), .rom_instr(b_rom_instr),
    .rom_addr(b_rom_addr), .rom_rdata(b_rom_rdata),
    .rom_ready(b_rom_ready),
    .ram_valid(b_ram_valid), .ram_addr(b_ram_addr),
    .ram_wdata(b_ram_wdata), .ram_wstrb(b_ram_wstrb),
    .ram_ready(b_ram_ready),
    .busy(b_busy), .done(b_done), .error(b_error),
    .core_reset(b_core_reset)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h4101_4081 + a;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ROM A: one-cycle latency unless hung.
  always @(posedge clock) begin
    a_rom_ready <= 1'b0;
    if (!reset && a_rom_valid && !rom_hang) begin
      a_rom_ready <= 1'b1;
      a_rom_rdata <= rom_word(a_rom_addr);
    end
  end

  // RAM A: ready ram_lat cycles after the request.
  always @(posedge clock) begin
    a_ram_ready <= 1'b0;
    if (reset)
      wcnt <= 0;
    else if (a_ram_valid) begin
      if (ram_lat <= 1) a_ram_ready <= 1'b1;
      else wcnt <= ram_lat - 1;
    end else if (wcnt != 0) begin
      wcnt <= wcnt - 1;
      if (wcnt == 1) a_ram_ready <= 1'b1;
    end
  end

  // ROM/RAM B: one-cycle responders.
  always @(posedge clock) begin
    b_rom_ready <= b_rom_valid && !reset;
    b_rom_rdata <= rom_word(b_rom_addr);
    b_ram_ready <= b_ram_valid && !reset;
  end

  // Monitor A writes against the scoreboard and check hold.
  initial begin
    wr_t e;
    bit  wpend;
    wpend = 1'b0;
    e = '0;
    forever begin
      @(negedge clock);
      if (reset) wpend = 1'b0;
      else if (a_ram_valid) begin
        nwr++;
        chk("a_wstrb", 32'(a_ram_wstrb), 32'hF);
        chk("a_write_expected", 32'(wq_a.size() != 0), 32'd1);
        if (wq_a.size() != 0) begin
          e = wq_a.pop_front();
          chk("a_ram_addr", a_ram_addr, e.addr);
          chk("a_ram_wdata", a_ram_wdata, e.data);
        end
        wpend = 1'b1;
      end else if (wpend) begin
        chk("a_addr_hold", a_ram_addr, e.addr);
        chk("a_wdata_hold", a_ram_wdata, e.data);
        chk("a_wstrb_idle", 32'(a_ram_wstrb), 32'd0);
        if (a_ram_ready) wpend = 1'b0;
      end
    end
  end

  // Monitor B reads and writes.
  initial begin
    wr_t e;
    forever begin
      @(negedge clock);
      if (!reset && b_rom_valid) begin
        chk("b_read_expected", 32'(rq_b.size() != 0), 32'd1);
        if (rq_b.size() != 0)
          chk("b_rom_addr", b_rom_addr, rq_b.pop_front());
      end
      if (!reset && b_ram_valid) begin
        chk("b_write_expected", 32'(wq_b.size() != 0), 32'd1);
        if (wq_b.size() != 0) begin
          e = wq_b.pop_front();
          chk("b_ram_addr", b_ram_addr, e.addr);
          chk("b_ram_wdata", b_ram_wdata, e.data);
        end
      end
    end
  end

  task automatic push_a(input int words);
    for (int i = 0; i < words; i++)
      wq_a.push_back('{addr: 32'h8000_0000 + 32'(4 * i),
                       data: rom_word(32'(4 * i))});
  endtask

  task automatic start_a();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done_a(output int n, output logic crp);
    n = 0;
    crp = a_core_reset;
    do begin
      @(negedge clock);
      n++;
      if (!a_done) crp = a_core_reset;
    end while (!a_done && n < 400);
  endtask

  initial begin
    int   n, n0, k;
    logic crp;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_rom_valid", 32'(a_rom_valid), 32'd0);
    chk("rst_rom_instr", 32'(a_rom_instr), 32'd1);
    chk("rst_rom_addr", a_rom_addr, 32'h0);
    chk("rst_ram_valid", 32'(a_ram_valid), 32'd0);
    chk("rst_ram_addr", a_ram_addr, 32'h8000_0000);
    chk("rst_ram_wdata", a_ram_wdata, 32'h0);
    chk("rst_ram_wstrb", 32'(a_ram_wstrb), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_error", 32'(a_error), 32'd0);
    chk("rst_core_reset", 32'(a_core_reset), 32'd1);
    chk("rst_b_rom_addr", b_rom_addr, 32'hFFFF_FFFC);
    reset = 1'b0;

    // Basic copy
    push_a(4);
    n0 = nwr;
    start_a();
    wait_done_a(n, crp);
    chk("basic_done_cycle", n, 18);
    chk("basic_core_reset_before", 32'(crp), 32'd1);
    chk("basic_core_reset_after", 32'(a_core_reset), 32'd0);
    chk("basic_error", 32'(a_error), 32'd0);
    chk("basic_busy", 32'(a_busy), 32'd0);
    chk("basic_writes", nwr - n0, 4);
    chk("basic_queue", wq_a.size(), 0);

    // Slow RAM
    ram_lat = 6;
    push_a(4);
    n0 = nwr;
    start_a();
    wait_done_a(n, crp);
    chk("slow_done_cycle", n, 38);
    chk("slow_error", 32'(a_error), 32'd0);
    chk("slow_writes", nwr - n0, 4);
    chk("slow_queue", wq_a.size(), 0);

    // Start while busy
    ram_lat = 1;
    push_a(4);
    n0 = nwr;
    start_a();
    repeat (6) @(negedge clock);
    chk("sb_busy_mid", 32'(a_busy), 32'd1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done_a(n, crp);
    chk("sb_done_cycle", 7 + n, 18);
    chk("sb_writes", nwr - n0, 4);
    chk("sb_queue", wq_a.size(), 0);

    // Timeout on a hung ROM
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    rom_hang = 1'b1;
    n0 = nwr;
    start_a();
    wait_done_a(n, crp);
    chk("to_done_cycle", n, 10);
    chk("to_error", 32'(a_error), 32'd1);
    chk("to_core_reset", 32'(a_core_reset), 32'd1);
    chk("to_no_writes", nwr - n0, 0);
    @(negedge clock);
    chk("to_done_sticky", 32'(a_done), 32'd1);
    chk("to_error_sticky", 32'(a_error), 32'd1);
    rom_hang = 1'b0;

    // Reset during the third write's wait
    ram_lat = 6;
    push_a(4);
    n0 = nwr;
    start_a();
    k = 0;
    while (nwr - n0 < 3 && k < 200) begin
      @(negedge clock);
      k++;
    end
    chk("mid_reached_word2", nwr - n0, 3);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rom_valid", 32'(a_rom_valid), 32'd0);
    chk("mid_ram_valid", 32'(a_ram_valid), 32'd0);
    chk("mid_busy", 32'(a_busy), 32'd0);
    chk("mid_core_reset", 32'(a_core_reset), 32'd1);
    reset = 1'b0;
    wq_a.delete();
    repeat (8) @(negedge clock);
    ram_lat = 1;
    push_a(4);
    n0 = nwr;
    start_a();
    wait_done_a(n, crp);
    chk("rerun_done_cycle", n, 18);
    chk("rerun_error", 32'(a_error), 32'd0);
    chk("rerun_core_reset", 32'(a_core_reset), 32'd0);
    chk("rerun_writes", nwr - n0, 4);
    chk("rerun_queue", wq_a.size(), 0);

    // Source address wrap
    rq_b.push_back(32'hFFFF_FFFC);
    rq_b.push_back(32'h0000_0000);
    wq_b.push_back('{addr: 32'h8000_0000,
                     data: rom_word(32'hFFFF_FFFC)});
    wq_b.push_back('{addr: 32'h8000_0004,
                     data: rom_word(32'h0)});
    @(negedge clock);
    start_b = 1'b1;
    @(posedge clock);
    #1 start_b = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!b_done && n < 400);
    chk("wrap_done_cycle", n, 10);
    chk("wrap_error", 32'(b_error), 32'd0);
    chk("wrap_core_reset", 32'(b_core_reset), 32'd0);
    chk("wrap_reads", rq_b.size(), 0);
    chk("wrap_writes", wq_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
